// File: rtl/config_chain_loader_pkg.sv
// Shared types for the configuration chain loader: FSM state encoding and
// default sizing of the word port and downstream chain.
package config_chain_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_SET       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_CHAIN_LEN = 1024;

endpackage

// File: rtl/config_chain_loader.sv
// Serializes config words LSB-first onto the tile shift chain, then pulses
// set_out so the chain latches its shadow registers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no load in progress, waiting for start
// WAIT_WORD | word_ready high, chain held (cen=0) until a word arrives
// SHIFT     | one config bit per cycle on shift_out with cen=1
// SET       | set_out pulse after the final chain bit
// DONE      | done pulse, busy drops on exit
module config_chain_loader
    import config_chain_loader_pkg::*;
#(
    parameter int  WORD_W    = DEF_WORD_W,
    parameter int  CHAIN_LEN = DEF_CHAIN_LEN,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              shift_out,
    output logic              cen,
    output logic              set_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_left
);

    localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] sreg_nxt;
    logic [IDX_W-1:0]  bit_idx;

    assign sreg_nxt = sreg >> 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_idx    <= '0;
            word_ready <= 1'b0;
            shift_out  <= 1'b0;
            cen        <= 1'b0;
            set_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bits_left  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_WAIT_WORD;
                        bits_left  <= FULL_CNT;
                        busy       <= 1'b1;
                        word_ready <= 1'b1;
                    end
                end
                ST_WAIT_WORD: begin
                    if (word_valid) begin
                        sreg       <= word_data;
                        bit_idx    <= '0;
                        shift_out  <= word_data[0];
                        cen        <= 1'b1;
                        word_ready <= 1'b0;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg    <= sreg_nxt;
                    bit_idx <= bit_idx + 1'b1;
                    if (bits_left != '0) begin
                        bits_left <= bits_left - 1'b1;
                    end
                    // The chain-length check wins so a partial final word is cut short.
                    if (bits_left <= CNT_W'(1)) begin
                        cen       <= 1'b0;
                        shift_out <= 1'b0;
                        set_out   <= 1'b1;
                        state     <= ST_SET;
                    end else if (bit_idx == LAST_IDX) begin
                        cen        <= 1'b0;
                        shift_out  <= 1'b0;
                        word_ready <= 1'b1;
                        state      <= ST_WAIT_WORD;
                    end else begin
                        shift_out <= sreg_nxt[0];
                    end
                end
                ST_SET: begin
                    set_out <= 1'b0;
                    done    <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Randomized bench for config_chain_loader: a bit-queue reference model is
// compared against the DUT every cycle, plus literal checks on directed loads.
module tb_config_chain_loader;

    localparam int WORD_W    = 16;
    localparam int CHAIN_LEN = 40;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic              clk;
    logic              rst;
    logic              start;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              shift_out;
    logic              cen;
    logic              set_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bits_left;

    config_chain_loader #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .shift_out  (shift_out),
        .cen        (cen),
        .set_out    (set_out),
        .busy       (busy),
        .done       (done),
        .bits_left  (bits_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: pending chain bits held as a queue of the accepted word's bits.
    bit m_q[$];
    bit m_busy = 1'b0;
    bit m_set  = 1'b0;
    bit m_done = 1'b0;
    int m_left = 0;

    int cyc = 0, cen_cnt = 0, set_cnt = 0, done_cnt = 0;
    int last_cen_cyc = 0, set_cyc = 0, done_cyc = 0;
    bit stream[$];

    always @(negedge clk) begin
        cyc++;
        chk("word_ready", word_ready, m_busy && m_q.size() == 0 && m_left > 0 && !m_set && !m_done);
        chk("cen", cen, m_q.size() > 0);
        if (m_q.size() > 0) chk("shift_out", shift_out, m_q[0]);
        chk("set_out", set_out, m_set);
        chk("done", done, m_done);
        chk("busy", busy, m_busy);
        chk("bits_left", bits_left, m_left);

        if (cen === 1'b1) begin
            stream.push_back(shift_out);
            cen_cnt++;
            last_cen_cyc = cyc;
        end
        if (set_out === 1'b1) begin set_cnt++;  set_cyc = cyc;  end
        if (done === 1'b1)    begin done_cnt++; done_cyc = cyc; end

        // Advance the model to what the upcoming edge must produce.
        if (!rst) begin
            m_q.delete();
            m_busy = 0; m_set = 0; m_done = 0; m_left = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_set) begin
            m_set = 0; m_done = 1;
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_left--;
            if (m_left == 0) begin
                m_set = 1;
                m_q.delete();
            end
        end else if (m_busy && m_left > 0) begin
            if (word_valid)
                for (int i = 0; i < WORD_W && i < m_left; i++) m_q.push_back(word_data[i]);
        end else if (!m_busy && start) begin
            m_busy = 1;
            m_left = CHAIN_LEN;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_load(input bit directed, input int gap_max, input bit poke_start, input string tag);
        logic [WORD_W-1:0] words[$];
        logic [CHAIN_LEN-1:0] got;
        int  cen0  = cen_cnt;
        int  set0  = set_cnt;
        int  done0 = done_cnt;
        int  s0    = stream.size();
        bit  finished = 0;
        bit  poked    = 0;
        bit  xfer;
        if (directed) words = '{16'hA5C3, 16'h0F0F, 16'hFF12};
        else for (int i = 0; i < 3; i++) words.push_back(WORD_W'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (words.size() > 0 && $urandom_range(0, gap_max) == 0) begin
                word_valid = 1'b1;
                word_data  = words[0];
            end else begin
                word_valid = 1'b0;
                word_data  = WORD_W'($urandom);
            end
            if (poke_start && !poked && cen) begin
                start = 1'b1;
                poked = 1;
            end else begin
                start = 1'b0;
            end
            xfer = word_valid && word_ready;
            tick();
            if (xfer) void'(words.pop_front());
            if (done) finished = 1;
        end
        word_valid = 1'b0;
        start      = 1'b0;
        tick();
        chk({tag, "_completed"}, finished, 1);
        chk({tag, "_cen_count"}, cen_cnt - cen0, CHAIN_LEN);
        chk({tag, "_set_count"}, set_cnt - set0, 1);
        chk({tag, "_done_count"}, done_cnt - done0, 1);
        chk({tag, "_set_after_last_bit"}, set_cyc - last_cen_cyc, 1);
        chk({tag, "_done_after_set"}, done_cyc - set_cyc, 1);
        if (directed) begin
            got = '0;
            for (int i = 0; i < CHAIN_LEN; i++)
                if (s0 + i < stream.size()) got[i] = stream[s0 + i];
            chk({tag, "_stream"}, got, 40'h12_0F0F_A5C3);
        end
    endtask

    task automatic reset_mid_load();
        int  n_acc = 0;
        int  set0  = set_cnt;
        int  done0 = done_cnt;
        bit  xfer;
        bit  hit   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            word_valid = 1'b1;
            word_data  = WORD_W'($urandom);
            xfer = word_valid && word_ready;
            tick();
            if (xfer) n_acc++;
            if (n_acc == 2 && cen && bits_left < CNT_W'(CHAIN_LEN - WORD_W - 3)) hit = 1;
        end
        chk("rst_reached_second_word", hit, 1);
        rst   = 1'b0;
        start = 1'b1;
        tick();
        chk("rst_word_ready", word_ready, 0);
        chk("rst_cen", cen, 0);
        chk("rst_shift_out", shift_out, 0);
        chk("rst_set_out", set_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bits_left", bits_left, 0);
        rst        = 1'b1;
        start      = 1'b0;
        word_valid = 1'b0;
        repeat (5) tick();
        chk("rst_no_set_out", set_cnt - set0, 0);
        chk("rst_no_done", done_cnt - done0, 0);
        run_load(0, 2, 0, "reload");
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        repeat (3) tick();
        chk("init_busy", busy, 0);
        chk("init_cen", cen, 0);
        chk("init_bits_left", bits_left, 0);
        rst = 1'b1;
        tick();

        run_load(1, 0, 0, "directed");
        repeat (2) tick();
        run_load(0, 5, 0, "gaps");
        run_load(0, 1, 1, "start_mid");
        reset_mid_load();
        for (int i = 0; i < 6; i++) begin
            run_load(0, 3, 1'($urandom_range(0, 1)), "rand");
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
